pc_gen: RTL

- Parametrised program-counter generator for the fetch stage; next generation of the single-width free-running PC register.
- Adds:
  - configurable address width, reset vector and instruction size
  - pipeline stall
  - branch redirect and exception redirect with fixed priority
  - a one-entry pending-redirect buffer honouring the instruction-memory ready handshake
  - halt mode
- Drives the instruction-memory address and chip enable directly.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_redirect_buf.sv | 60 ++++++
 rtl/pc_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    NONE,
    REDIR,
    EXC
  } pend_kind_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Low-order bits that must be zero in an instruction-aligned address.
  function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
    return 64'(inst_bytes) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer plus the redirect-source priority mux
// (live exception > pending exception > live redirect > pending redirect).
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              clear,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  output logic              sel_valid,
  output logic [ADDR_W-1:0] sel_target,
  output logic              pending
);

  pend_kind_t        kind;
  logic [ADDR_W-1:0] target;

  // Exceptions overwrite anything; a redirect only replaces an older redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind   <= NONE;
      target <= '0;
    end else if (clear) begin
      kind <= NONE;
    end else if (capture) begin
      if (exc_valid) begin
        kind   <= EXC;
        target <= exc_target;
      end else if (redir_valid && (kind != EXC)) begin
        kind   <= REDIR;
        target <= redir_target;
      end
    end
  end

  always_comb begin
    sel_valid  = DISABLE;
    sel_target = target;
    if (exc_valid) begin
      sel_valid  = ENABLE;
      sel_target = exc_target;
    end else if (kind == EXC) begin
      sel_valid = ENABLE;
    end else if (redir_valid) begin
      sel_valid  = ENABLE;
      sel_target = redir_target;
    end else if (kind == REDIR) begin
      sel_valid = ENABLE;
    end
  end

  assign pending = (kind != NONE);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential advance, stall, halt and
// prioritised branch/exception redirects gated by the memory ready handshake.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       INST_BYTES  = 4,
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic              exc_valid_i,
  input  logic [ADDR_W-1:0] exc_vector_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o,
  output logic              redir_pending_o
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(align_mask(INST_BYTES));
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);

  pc_state_t         state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              ce_q, ce_n;
  logic              mis_q, mis_n;
  logic              capture, clear, take, advance;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_target, sel_aligned;
  logic              sel_mis;

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (capture),
    .clear       (clear),
    .exc_valid   (exc_valid_i),
    .exc_target  (exc_vector_i),
    .redir_valid (redirect_valid_i),
    .redir_target(redirect_target_i),
    .sel_valid   (sel_valid),
    .sel_target  (sel_target),
    .pending     (redir_pending_o)
  );

  always_comb begin
    if (ALIGN_CHECK) begin
      sel_mis     = |(sel_target & LOW_MASK);
      sel_aligned = sel_target & ~LOW_MASK;
    end else begin
      sel_mis     = DISABLE;
      sel_aligned = sel_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= RESET_VEC;
      ce_q  <= DISABLE;
      mis_q <= DISABLE;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      ce_q  <= ce_n;
      mis_q <= mis_n;
    end
  end

  // pc/ce only move on ready edges; otherwise strobes are parked in the buffer.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ce_n    = ce_q;
    mis_n   = DISABLE;
    capture = DISABLE;
    clear   = DISABLE;
    take    = DISABLE;
    advance = DISABLE;
    case (state)
      IDLE: begin
        state_n = RUN;
        ce_n    = ENABLE;
        capture = ENABLE;
      end
      RUN: begin
        if (!fetch_ready_i) begin
          capture = ENABLE;
        end else if (halt_i) begin
          state_n = HALT;
          ce_n    = DISABLE;
          capture = ENABLE;
        end else begin
          take    = ENABLE;
          advance = !stall_i;
        end
      end
      HALT: begin
        if (halt_i || !fetch_ready_i) begin
          capture = ENABLE;
        end else begin
          state_n = RUN;
          ce_n    = ENABLE;
          take    = ENABLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take && sel_valid) begin
      pc_n  = sel_aligned;
      mis_n = sel_mis;
      clear = ENABLE;
    end else if (advance) begin
      pc_n = pc_q + INC;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign misalign_o = mis_q;

endmodule
